// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet geometry, NIC register map, header fields
// and the channel-buffer state encoding.
package noc_pkg;

  localparam int unsigned PACKET_SIZE = 64;

  localparam int unsigned ADDR_IB  = 0;
  localparam int unsigned ADDR_IBS = 1;
  localparam int unsigned ADDR_OB  = 2;
  localparam int unsigned ADDR_OBS = 3;

  localparam int unsigned VC        = 63;
  localparam int unsigned HDIR      = 62;
  localparam int unsigned VDIR      = 61;
  localparam int unsigned HHOP_MSB  = 55;
  localparam int unsigned HHOP_LSB  = 52;
  localparam int unsigned VHOP_MSB  = 51;
  localparam int unsigned VHOP_LSB  = 48;
  localparam int unsigned SRC_MSB   = 47;
  localparam int unsigned SRC_LSB   = 32;
  localparam int unsigned DST_MSB   = 31;
  localparam int unsigned DST_LSB   = 16;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/nic_chan_buf.sv
// One-entry channel buffer: EMPTY/FULL FSM plus data register.
// A load while FULL is ignored; the caller decides whether that is an error.
module nic_chan_buf #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         unload,
  output logic         full,
  output logic [W-1:0] data
);
  import noc_pkg::*;

  buf_state_e   state_q, state_d;
  logic [W-1:0] data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= BUF_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BUF_EMPTY: if (load)   state_d = BUF_FULL;
      BUF_FULL:  if (unload) state_d = BUF_EMPTY;
      default:               state_d = BUF_EMPTY;
    endcase
  end

  always_comb begin
    full = (state_q == BUF_FULL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             data_q <= '0;
    else if (state_q == BUF_EMPTY && load) data_q <= load_data;
  end

  assign data = data_q;

endmodule

// File: rtl/pe_nic.sv
// PE-side network interface: 2-bit register window over an eject buffer (IB)
// and an inject buffer (OB) facing the local router port.
module pe_nic #(
  parameter int unsigned PACKET_SIZE = 64,
  parameter int unsigned ADDR_W      = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [PACKET_SIZE-1:0] d_in,
  output logic [PACKET_SIZE-1:0] d_out,
  input  logic                   nicEn,
  input  logic                   nicWrEn,
  output logic                   net_so,
  input  logic                   net_ro,
  output logic [PACKET_SIZE-1:0] net_do,
  input  logic                   net_si,
  output logic                   net_ri,
  input  logic [PACKET_SIZE-1:0] net_di,
  input  logic                   net_polarity
);
  import noc_pkg::*;

  logic                   rd_en, wr_en;
  logic                   ib_load, ib_unload, ib_full;
  logic                   ob_load, ob_full;
  logic [PACKET_SIZE-1:0] ib_data, ob_data, rd_data, d_out_q;
  logic                   overflow_q;

  assign rd_en = nicEn & ~nicWrEn;
  assign wr_en = nicEn &  nicWrEn;

  // net_ri comes straight from the IB state register, so a read on the same
  // edge as net_si never captures: the buffer still looks full at that edge.
  assign net_ri    = ~ib_full;
  assign ib_load   = net_si & net_ri;
  assign ib_unload = rd_en & (addr == ADDR_W'(ADDR_IB));

  assign ob_load = wr_en & (addr == ADDR_W'(ADDR_OB));
  assign net_so  = ob_full & net_ro & (net_polarity == ob_data[VC]);
  assign net_do  = ob_data;

  nic_chan_buf #(.W(PACKET_SIZE)) u_ib (
    .clk       (clk),
    .reset     (reset),
    .load      (ib_load),
    .load_data (net_di),
    .unload    (ib_unload),
    .full      (ib_full),
    .data      (ib_data)
  );

  nic_chan_buf #(.W(PACKET_SIZE)) u_ob (
    .clk       (clk),
    .reset     (reset),
    .load      (ob_load),
    .load_data (d_in),
    .unload    (net_so),
    .full      (ob_full),
    .data      (ob_data)
  );

  // A write judged against a FULL OB is dropped even if it drains this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                      overflow_q <= 1'b0;
    else if (ob_load && ob_full)                     overflow_q <= 1'b1;
    else if (rd_en && addr == ADDR_W'(ADDR_OBS))     overflow_q <= 1'b0;
  end

  always_comb begin
    rd_data = '0;
    if (addr == ADDR_W'(ADDR_IB)) begin
      rd_data = ib_data;
    end else if (addr == ADDR_W'(ADDR_IBS)) begin
      rd_data[0] = ib_full;
    end else if (addr == ADDR_W'(ADDR_OBS)) begin
      rd_data[0] = ob_full;
      rd_data[1] = overflow_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     d_out_q <= '0;
    else if (rd_en) d_out_q <= rd_data;
  end

  assign d_out = d_out_q;

endmodule

// File: tb/tb_pe_nic.sv
// Self-checking bench for pe_nic: register-window vector table plus
// directed inject/eject sequences with packet scoreboards.
module tb_pe_nic;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  addr = '0;
  logic [63:0] d_in = '0;
  logic [63:0] d_out;
  logic        nicEn = 1'b0;
  logic        nicWrEn = 1'b0;
  logic        net_so;
  logic        net_ro = 1'b0;
  logic [63:0] net_do;
  logic        net_si = 1'b0;
  logic        net_ri;
  logic [63:0] net_di = '0;
  logic        net_polarity = 1'b0;

  pe_nic #(.PACKET_SIZE(64), .ADDR_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_polarity (net_polarity)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;
  int inj_count = 0;
  logic [63:0] ob_q[$];
  logic [63:0] ib_q[$];

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [63:0] data;
    logic        push;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // Router side of the injection handshake: sampled mid-cycle, transfer at next edge.
  always @(negedge clk) begin
    if (reset === 1'b1 && net_so === 1'b1) begin
      inj_count++;
      if (ob_q.size() == 0) begin
        total++;
        $display("FAIL inject_unexpected: got %h, want no packet", net_do);
      end else begin
        check("inject", net_do, ob_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] d);
    addr = a; d_in = d; nicEn = 1'b1; nicWrEn = 1'b1;
    tick();
    nicEn = 1'b0; nicWrEn = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [63:0] exp, input string name);
    addr = a; nicEn = 1'b1; nicWrEn = 1'b0;
    tick();
    nicEn = 1'b0;
    check(name, d_out, exp);
  endtask

  task automatic wait_inj(input int target, input string name);
    for (int i = 0; i < 20 && inj_count < target; i++) tick();
    total++;
    if (inj_count >= target) passed++;
    else $display("FAIL %s: got %0d injections, want %0d (timeout)", name, inj_count, target);
  endtask

  task automatic eject(input logic [63:0] p);
    net_si = 1'b1; net_di = p;
    tick();
    net_si = 1'b0;
  endtask

  initial begin
    int base;

    vecs[0]  = '{1'b0, 2'd1, 64'h0, 1'b0, 64'h0, "rst_ibs"};
    vecs[1]  = '{1'b0, 2'd3, 64'h0, 1'b0, 64'h0, "rst_obs"};
    vecs[2]  = '{1'b1, 2'd0, 64'h1111_2222_3333_4444, 1'b0, 64'h0, "wr_ib_ignored"};
    vecs[3]  = '{1'b1, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0, "wr_ibs_ignored"};
    vecs[4]  = '{1'b1, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0, "wr_obs_ignored"};
    vecs[5]  = '{1'b0, 2'd1, 64'h0, 1'b0, 64'h0, "ibs_after_ignored"};
    vecs[6]  = '{1'b1, 2'd2, 64'h0000_0000_ABCD_0001, 1'b1, 64'h0, "wr_ob_a"};
    vecs[7]  = '{1'b1, 2'd2, 64'h0000_0000_ABCD_0002, 1'b0, 64'h0, "wr_ob_b_drop"};
    vecs[8]  = '{1'b0, 2'd3, 64'h0, 1'b0, 64'h3, "obs_overflow"};
    vecs[9]  = '{1'b0, 2'd3, 64'h0, 1'b0, 64'h1, "obs_ovf_cleared"};
    vecs[10] = '{1'b0, 2'd2, 64'h0, 1'b0, 64'h0, "rd_ob_zero"};
    vecs[11] = '{1'b0, 2'd1, 64'h0, 1'b0, 64'h0, "ibs_still_empty"};

    // Reset values while reset is held
    tick(); tick();
    check("rst_d_out", d_out, 64'h0);
    check("rst_net_so", {63'h0, net_so}, 64'h0);
    check("rst_net_ri", {63'h0, net_ri}, 64'h1);
    check("rst_net_do", net_do, 64'h0);
    reset = 1'b1;
    tick();

    // Single injection, matching polarity
    net_ro = 1'b1; net_polarity = 1'b0;
    base = inj_count;
    ob_q.push_back(64'h0030_DEAD_EA57_0000);
    wr(2'd2, 64'h0030_DEAD_EA57_0000);
    check("so_latency", {63'h0, net_so}, 64'h1);
    wait_inj(base + 1, "inject_basic");
    repeat (3) tick();
    check("inject_once", 64'(inj_count), 64'(base + 1));
    rd(2'd3, 64'h0, "obs_after_inject");

    // VC=1 packet held until polarity matches
    base = inj_count;
    ob_q.push_back(64'h8000_0000_0000_1234);
    wr(2'd2, 64'h8000_0000_0000_1234);
    for (int i = 0; i < 3; i++) begin
      check("vc_hold", {63'h0, net_so}, 64'h0);
      tick();
    end
    net_polarity = 1'b1;
    #1;
    check("vc_fire", {63'h0, net_so}, 64'h1);
    wait_inj(base + 1, "inject_vc1");
    tick();
    check("vc_so_low", {63'h0, net_so}, 64'h0);
    check("vc_once", 64'(inj_count), 64'(base + 1));
    net_polarity = 1'b0;

    // Register window table with router backpressure
    net_ro = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) begin
        if (vecs[i].push) ob_q.push_back(vecs[i].data);
        wr(vecs[i].addr, vecs[i].data);
      end else begin
        rd(vecs[i].addr, vecs[i].exp, vecs[i].name);
      end
    end
    base = inj_count;
    net_ro = 1'b1;
    wait_inj(base + 1, "inject_after_backpressure");
    repeat (3) tick();
    check("backpressure_once", 64'(inj_count), 64'(base + 1));
    net_ro = 1'b0;

    // Eject path
    ib_q.push_back(64'h0000_FACE_FEED_0000);
    eject(64'h0000_FACE_FEED_0000);
    check("ri_low", {63'h0, net_ri}, 64'h0);
    rd(2'd1, 64'h1, "ibs_full");
    rd(2'd0, ib_q.pop_front(), "ib_data");
    check("ri_high", {63'h0, net_ri}, 64'h1);
    rd(2'd0, 64'h0000_FACE_FEED_0000, "ib_stale");
    check("ri_stays_high", {63'h0, net_ri}, 64'h1);

    // Router holds net_si with two packets while the PE reads late
    ib_q.push_back(64'h0000_0001_0000_00A1);
    net_si = 1'b1; net_di = 64'h0000_0001_0000_00A1;
    tick();
    net_di = 64'h0000_0002_0000_00A2;
    for (int i = 0; i < 5; i++) begin
      check("hold_ri_low", {63'h0, net_ri}, 64'h0);
      tick();
    end
    ib_q.push_back(64'h0000_0002_0000_00A2);
    rd(2'd0, ib_q.pop_front(), "hold_first");
    check("hold_ri_reopen", {63'h0, net_ri}, 64'h1);
    tick();
    net_si = 1'b0;
    check("hold_second_captured", {63'h0, net_ri}, 64'h0);
    rd(2'd0, ib_q.pop_front(), "hold_second");
    rd(2'd1, 64'h0, "hold_no_dup");

    // Drain and addr-2 write on the same edge
    base = inj_count;
    ob_q.push_back(64'h0000_0000_0000_0C01);
    wr(2'd2, 64'h0000_0000_0000_0C01);
    net_ro = 1'b1; net_polarity = 1'b0;
    addr = 2'd2; d_in = 64'h0000_0000_0000_0C02; nicEn = 1'b1; nicWrEn = 1'b1;
    tick();
    nicEn = 1'b0; nicWrEn = 1'b0;
    check("coinc_so_low", {63'h0, net_so}, 64'h0);
    rd(2'd3, 64'h2, "coinc_obs");
    repeat (3) tick();
    check("coinc_one_inject", 64'(inj_count), 64'(base + 1));
    net_ro = 1'b0;

    // Reset with IB and OB both full
    eject(64'h0000_0000_0000_0E01);
    rd(2'd0, 64'h0000_0000_0000_0E01, "pre_rst_ib");
    eject(64'h0000_0000_0000_0E02);
    wr(2'd2, 64'h0000_0000_0000_0F01);
    check("pre_rst_ri", {63'h0, net_ri}, 64'h0);
    base = inj_count;
    reset = 1'b0;
    #1;
    check("arst_net_so", {63'h0, net_so}, 64'h0);
    check("arst_net_ri", {63'h0, net_ri}, 64'h1);
    check("arst_d_out", d_out, 64'h0);
    check("arst_net_do", net_do, 64'h0);
    tick(); tick();
    reset = 1'b1;
    net_ro = 1'b1;
    repeat (4) tick();
    check("arst_packet_lost", 64'(inj_count), 64'(base));
    rd(2'd3, 64'h0, "arst_obs");
    rd(2'd1, 64'h0, "arst_ibs");
    check("ob_queue_drained", 64'(ob_q.size()), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pe_nic.md
# pe_nic

Network interface between a processing element and the local port of its mesh router. It gives the PE a 2-bit memory-mapped register window. One channel buffer injects 64-bit packets into the router's PE input (send/ready handshake, polarity-gated). A second channel buffer accepts packets ejected by the router's PE output. One instance sits beside each router in the 4x4 mesh.

## Interface
- PACKET_SIZE, 64, packet and data-bus width; bit 63 is the virtual-channel (VC) bit.
- ADDR_W, 2, register address width.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low.
- addr  input  ADDR_W  register select: 0 input buffer, 1 input status, 2 output buffer, 3 output status.
- d_in  input  PACKET_SIZE  PE write data.
- d_out  output  PACKET_SIZE  registered PE read data.
- nicEn  input  1  access enable.
- nicWrEn  input  1  1 = write, 0 = read (qualified by nicEn).
- net_so  output  1  send to router PE input (drives router pesi).
- net_ro  input  1  router ready for injection (router peri).
- net_do  output  PACKET_SIZE  injected packet (router pedi).
- net_si  input  1  router ejecting packet (router peso).
- net_ri  output  1  NIC ready to accept ejection (router pero).
- net_di  input  PACKET_SIZE  ejected packet (router pedo).
- net_polarity  input  1  router polarity, toggles every cycle.

## Operation
- Two one-entry buffers, each a 2-state FSM: EMPTY and FULL.
- Input buffer (IB): EMPTY -> FULL on a clk edge with net_si & net_ri; net_di is latched.
  - FULL -> EMPTY on a PE read of addr 0.
  - net_ri = (IB state == EMPTY); it is driven from the register, not combinationally.
- Output buffer (OB): EMPTY -> FULL on a PE write to addr 2; d_in is latched.
  - FULL -> EMPTY on an edge where net_so & net_ro.
  - net_so = OB FULL & net_ro & (net_polarity == OB[63]); this is combinational.
  - net_do = OB data at all times.
- Register reads (nicEn & ~nicWrEn) load d_out at the edge:
  - addr 0: IB data.
  - addr 1: bit0 = IB full, other bits 0.
  - addr 2: returns 0.
  - addr 3: bit0 = OB full, bit1 = sticky overflow, other bits 0. A read of addr 3 clears overflow.
- Writes to addr 0, 1 and 3 are ignored.
- A write to addr 2 while OB is FULL is dropped, OB is unchanged, and overflow is set.
- A read of addr 0 while IB is EMPTY returns stale data, and the state stays EMPTY.
- Simultaneous events:
  - An OB drain and an addr-2 write on the same edge: the write is dropped because the buffer is judged FULL at the edge, and overflow is set.
  - An IB read on the same edge as net_si: no capture, because net_ri is 0.

## Timing
- Reset values: d_out=0, net_so=0, net_ri=1, net_do=0, both buffers EMPTY, overflow=0.
- Read latency: d_out is valid 1 cycle after the access edge and holds until the next read.
- Write-to-inject latency:
  - net_so can rise in the cycle after the write edge.
  - If polarity mismatches the VC bit, net_so rises one cycle later.
  - If net_ro is low, net_so waits for it.
- Eject-to-status: IB full is visible on the addr-1 read issued at the first edge after capture.
- net_ri falls the cycle after capture and rises the cycle after the IB read.
- Throughput: at most 1 packet per 2 cycles per direction.
- If reset is asserted mid-transfer, both buffers clear immediately; a pending OB packet is lost, and net_so drops asynchronously.

## Structure
- Shared package (noc_pkg):
  - PACKET_SIZE.
  - Address constants ADDR_IB=0, ADDR_IBS=1, ADDR_OB=2, ADDR_OBS=3.
  - Header field positions: VC=63, HDIR=62, VDIR=61, HHOP=55:52, VHOP=51:48, SRC=47:32, DST=31:16.
  - The buffer state enum.
- One sub-module, nic_chan_buf, is a one-entry buffer with FSM, data register and full flag. It is instantiated twice.

## Test plan
- Write 0x0030_DEAD_EA57_0000 to addr 2 with polarity=0 and net_ro=1.
  - net_so pulses exactly once, with net_do equal to that value.
  - An addr-3 read then returns 0.
- Write with VC=1 while polarity=0 and net_ro=1 -> net_so is held low until polarity=1, then fires once.
- Router drives net_si=1, net_di=0x0000_FACE_FEED_0000.
  - net_ri drops and an addr-1 read returns 1.
  - An addr-0 read returns 0x0000_FACE_FEED_0000 and net_ri returns to 1 one cycle later.
- Two back-to-back addr-2 writes with net_ro=0.
  - An addr-3 read returns 0x3, and a second addr-3 read returns 0x1.
  - The first packet is later injected intact.
- Router holds net_si=1 with two packets while the PE delays its read by 5 cycles -> the second packet is captured only after the read, with no loss or duplication.
- Assert reset while OB is FULL and net_ro=0 -> net_so=0, net_ri=1, d_out=0 immediately; addr-3 then reads 0.
